raster_line: RTL and testbench
==============================

Name: raster_line

Overview:
- Downstream neighbour of the clipping stage.
- Consumes clipped line segments (x0, y0, x1, y1, colour) through the clipper's raster_ready/vld handshake.
- Rasterizes each segment with integer Bresenham at 1 pixel/cycle and issues stallable pixel writes to the frame-buffer write port.
- Buffers segments already in flight, because the clipper's data lags raster_ready by 2 cycles.

Parameters:
- H_RES, 640, horizontal resolution; pixel address = y*H_RES + x
- V_RES, 480, vertical resolution
- CRD_W, 10, coordinate width
- COL_W, 3, colour width
- DEPTH, 2, segment buffer entries (min 2)
- ADDR_W, 19, frame-buffer address width

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- vld  in  1  segment on x0_in..color_in valid this cycle
- x0_in, y0_in, x1_in, y1_in  in  CRD_W each  endpoints, unsigned
- color_in  in  COL_W  line colour
- raster_ready  out  1  credit request to clipper
- fb_we  out  1  pixel write request
- fb_addr  out  ADDR_W  pixel address
- fb_wdata  out  COL_W  pixel colour
- fb_stall  in  1  frame buffer cannot accept this cycle
- line_done  out  1  one-cycle pulse after last pixel of a segment is accepted
- idle  out  1  FSM IDLE, buffer empty, no credits outstanding
- ovf_err  out  1  sticky: vld arrived with buffer full

Behaviour:
- Reset values (all async): raster_ready=0, fb_we=0, fb_addr=0, fb_wdata=0, line_done=0, ovf_err=0, idle=1. Buffer and credit pipe are emptied.
- Credit scheme:
  - pend = raster_ready delayed 1 cycle + raster_ready delayed 2 cycles.
  - raster_ready (registered) next = (occ + pend + raster_ready) < DEPTH, where occ is buffer occupancy.
  - This guarantees every vld finds space.
- vld with occ==DEPTH: segment dropped, ovf_err set until reset.
- Buffer: FIFO of {x0,y0,x1,y1,color}.
  - Push on vld; pop by FSM.
  - Simultaneous push and pop when full is legal, as long as the pop happens first.
- FSM:
  - IDLE: if occ>0, pop the head into working regs, go to SETUP.
  - SETUP (1 cycle):
    - x=x0, y=y0
    - dx=|x1-x0|, dy=-|y1-y0|
    - sx=+1 if x0<x1 else -1; sy likewise
    - err=dx+dy
    - go to DRAW.
  - DRAW:
    - fb_we=1, fb_addr=y*H_RES+x, computed as (y<<9)+(y<<7)+x for 640.
    - fb_wdata=colour.
    - Outputs are driven from registers and held stable while fb_stall=1.
    - Write is accepted when fb_we && !fb_stall.
    - On accept with (x,y)==(x1,y1): line_done pulses next cycle, FSM goes to IDLE.
    - Otherwise, with e2=2*err: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates apply in the same cycle.
- Widths: err is 12-bit signed, e2 is 13-bit signed; dx, dy are 11-bit signed.
- Latency: vld at cycle t with buffer empty and FSM IDLE → pop t+1, SETUP t+2, first fb_we t+3.
- Back-to-back: IDLE→SETUP costs 2 dead cycles between segments.
- Degenerate point (x0==x1, y0==y1): exactly one write.
- Pixels outside H_RES×V_RES: fb_we suppressed for that step, stepping continues, no error. The clipper guarantees range, so this is defensive only.
- idle = (state==IDLE) && occ==0 && pend==0 && !raster_ready.
- Reset mid-line: line abandoned, no line_done, buffered segments lost.

Decomposition:
- Shared package raster_pkg:
  - H_RES, V_RES, CRD_W, COL_W, ADDR_W
  - state enum {IDLE, SETUP, DRAW}
  - segment struct {x0,y0,x1,y1,color}
- One sub-module: raster_seg_fifo (DEPTH-entry synchronous FIFO with occ count). Also usable by the clipper's replacement FIFOs.

Test Plan:
- Horizontal: (0,0)-(3,0) colour 5, no stall → fb_addr 0,1,2,3 on 4 consecutive cycles, fb_wdata=5, first fb_we 3 cycles after vld, single line_done.
- Steep: (10,10)-(12,15) colour 2 → addrs 6410,7050,7691,8331,8972,9612 in order.
- Reverse and point: (3,0)-(0,0) → addrs 3,2,1,0. Then (639,479)-(639,479) → exactly one write at addr 307199.
- Stall: (0,0)-(3,0) with fb_stall=1 for 3 cycles while addr 1 is presented → fb_we/fb_addr=1 held 4 cycles, sequence still 0,1,2,3, no duplicates.
- Credits: drive clipper-model vld 2 cycles after each raster_ready with 3 queued segments → raster_ready never lets occ+pend exceed 2, ovf_err stays 0, segments drawn in order. Forced vld while full → ovf_err=1, segment dropped.
- Reset: assert rst_n=0 in the middle of DRAW → all outputs at reset values immediately, idle=1, no line_done, next segment draws normally.

Source files
------------

// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raster_pkg
//  Description : Shared types, sizes and helpers for the line rasterizer and
//                its segment buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package raster_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int CRD_W  = 10;
    localparam int COL_W  = 3;
    localparam int ADDR_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CRD_W-1:0] x0;
        logic [CRD_W-1:0] y0;
        logic [CRD_W-1:0] x1;
        logic [CRD_W-1:0] y1;
        logic [COL_W-1:0] color;
    } seg_t;

    // Linear frame-buffer address; 640 = 512 + 128 so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [CRD_W-1:0] x,
                                                   input logic [CRD_W-1:0] y);
        logic [ADDR_W-1:0] xa;
        logic [ADDR_W-1:0] ya;
        xa = ADDR_W'(x);
        ya = ADDR_W'(y);
        if (H_RES == 640)
            return (ya << 9) + (ya << 7) + xa;
        else
            return ya * ADDR_W'(H_RES) + xa;
    endfunction

    // True when the pixel lies inside the visible raster.
    function automatic logic in_range(input logic [CRD_W-1:0] x,
                                      input logic [CRD_W-1:0] y);
        return (int'(x) < H_RES) && (int'(y) < V_RES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_seg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : raster_seg_fifo
//  Description : DEPTH-entry synchronous FIFO of line segments with an
//                occupancy count. A push into a full FIFO is accepted when a
//                pop happens in the same cycle (pop frees the slot first).
//  Revision    : 1.0  initial release
// ============================================================================
module raster_seg_fifo
    import raster_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  seg_t             din,
    input  logic             pop,
    output seg_t             dout,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    seg_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written on accepted push, no reset needed for data.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/raster_line.sv
`default_nettype none
// ============================================================================
//  Module      : raster_line
//  Description : Bresenham line rasterizer. Accepts clipped segments through
//                a credit handshake, buffers them, and emits one stallable
//                frame-buffer write per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module raster_line
    import raster_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld,
    input  logic [CRD_W-1:0]  x0_in,
    input  logic [CRD_W-1:0]  y0_in,
    input  logic [CRD_W-1:0]  x1_in,
    input  logic [CRD_W-1:0]  y1_in,
    input  logic [COL_W-1:0]  color_in,
    output logic              raster_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]  fb_wdata,
    input  logic              fb_stall,
    output logic              line_done,
    output logic              idle,
    output logic              ovf_err
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // ---------------- segment buffer ----------------
    seg_t             seg_in;
    seg_t             head;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             empty;
    logic             pop;

    assign seg_in = '{x0: x0_in, y0: y0_in, x1: x1_in, y1: y1_in, color: color_in};

    raster_seg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld),
        .din   (seg_in),
        .pop   (pop),
        .dout  (head),
        .occ   (occ),
        .full  (full),
        .empty (empty)
    );

    // ---------------- credit pipe ----------------
    // The clipper answers a credit two cycles later, so credits still in
    // flight count against buffer space just like stored segments.
    logic       rr_d1;
    logic       rr_d2;
    logic [1:0] pend;
    int         credit_sum;

    assign pend       = {1'b0, rr_d1} + {1'b0, rr_d2};
    assign credit_sum = int'(occ) + int'(pend) + int'(raster_ready);

    // Credit request and its two-cycle history; sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raster_ready <= 1'b0;
            rr_d1        <= 1'b0;
            rr_d2        <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            raster_ready <= (credit_sum < DEPTH);
            rr_d1        <= raster_ready;
            rr_d2        <= rr_d1;
            if (vld && full && !pop)
                ovf_err <= 1'b1;
        end
    end

    // ---------------- FSM ----------------
    state_t state;
    state_t state_nxt;
    logic   load;
    logic   advance;
    logic   finish;
    logic   step;
    logic   at_end;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_DRAW;
            ST_DRAW:  if (finish) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes. A suppressed (off-screen) pixel advances without waiting.
    always_comb begin
        pop     = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            ST_IDLE:  pop     = !empty;
            ST_SETUP: load    = 1'b1;
            ST_DRAW:  advance = !fb_we || !fb_stall;
            default:  ;
        endcase
        finish = advance && at_end;
        step   = advance && !at_end;
    end

    // ---------------- Bresenham datapath ----------------
    seg_t                    seg;
    logic [CRD_W-1:0]        x;
    logic [CRD_W-1:0]        y;
    logic                    x_inc;
    logic                    y_inc;
    logic signed [CRD_W:0]   dx;
    logic signed [CRD_W:0]   dy;
    logic signed [CRD_W+1:0] err;

    logic [CRD_W-1:0]        adx;
    logic [CRD_W-1:0]        ady;
    logic signed [CRD_W:0]   dx_init;
    logic signed [CRD_W:0]   dy_init;
    logic signed [CRD_W+1:0] err_init;

    logic signed [CRD_W+2:0] e2;
    logic signed [CRD_W+2:0] dx_e;
    logic signed [CRD_W+2:0] dy_e;
    logic signed [CRD_W+1:0] dx_w;
    logic signed [CRD_W+1:0] dy_w;
    logic                    step_x;
    logic                    step_y;
    logic signed [CRD_W+1:0] err_nxt;
    logic [CRD_W-1:0]        x_nxt;
    logic [CRD_W-1:0]        y_nxt;

    // Initial deltas from the popped segment.
    always_comb begin
        adx      = (seg.x1 >= seg.x0) ? (seg.x1 - seg.x0) : (seg.x0 - seg.x1);
        ady      = (seg.y1 >= seg.y0) ? (seg.y1 - seg.y0) : (seg.y0 - seg.y1);
        dx_init  = $signed({1'b0, adx});
        dy_init  = -$signed({1'b0, ady});
        err_init = dx_init + dy_init;
    end

    // One Bresenham step; both axis updates use the same e2.
    always_comb begin
        e2      = {err, 1'b0};
        dx_e    = dx;
        dy_e    = dy;
        dx_w    = dx;
        dy_w    = dy;
        step_x  = (e2 >= dy_e);
        step_y  = (e2 <= dx_e);
        err_nxt = err;
        x_nxt   = x;
        y_nxt   = y;
        if (step_x) begin
            err_nxt = err_nxt + dy_w;
            x_nxt   = x_inc ? x + CRD_W'(1) : x - CRD_W'(1);
        end
        if (step_y) begin
            err_nxt = err_nxt + dx_w;
            y_nxt   = y_inc ? y + CRD_W'(1) : y - CRD_W'(1);
        end
        at_end = (x == seg.x1) && (y == seg.y1);
    end

    // Working registers and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= '0;
            x         <= '0;
            y         <= '0;
            x_inc     <= 1'b0;
            y_inc     <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_wdata  <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= finish;
            if (pop)
                seg <= head;
            if (load) begin
                x        <= seg.x0;
                y        <= seg.y0;
                x_inc    <= (seg.x0 < seg.x1);
                y_inc    <= (seg.y0 < seg.y1);
                dx       <= dx_init;
                dy       <= dy_init;
                err      <= err_init;
                fb_we    <= in_range(seg.x0, seg.y0);
                fb_addr  <= pix_addr(seg.x0, seg.y0);
                fb_wdata <= seg.color;
            end else if (step) begin
                x       <= x_nxt;
                y       <= y_nxt;
                err     <= err_nxt;
                fb_we   <= in_range(x_nxt, y_nxt);
                fb_addr <= pix_addr(x_nxt, y_nxt);
            end else if (finish) begin
                fb_we <= 1'b0;
            end
        end
    end

    assign idle = (state == ST_IDLE) && empty && (pend == 2'd0) && !raster_ready;

endmodule
`default_nettype wire

// File: tb/tb_raster_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raster_line
//  Description : Directed self-checking bench for raster_line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_raster_line;
    import raster_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vld = 1'b0;
    logic [CRD_W-1:0]  x0_in = '0;
    logic [CRD_W-1:0]  y0_in = '0;
    logic [CRD_W-1:0]  x1_in = '0;
    logic [CRD_W-1:0]  y1_in = '0;
    logic [COL_W-1:0]  color_in = '0;
    logic              fb_stall = 1'b0;
    logic              raster_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [COL_W-1:0]  fb_wdata;
    logic              line_done;
    logic              idle;
    logic              ovf_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];

    raster_line #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .x0_in        (x0_in),
        .y0_in        (y0_in),
        .x1_in        (x1_in),
        .y1_in        (y1_in),
        .color_in     (color_in),
        .raster_ready (raster_ready),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_stall     (fb_stall),
        .line_done    (line_done),
        .idle         (idle),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted writes and line_done pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_we && !fb_stall) begin
                wr_addr_q.push_back(int'(fb_addr));
                wr_data_q.push_back(int'(fb_wdata));
                wr_cyc_q.push_back(cyc);
            end
            if (line_done)
                done_cnt++;
        end
    end

    task automatic drive_seg(input int ax0, input int ay0, input int ax1,
                             input int ay1, input int acol);
        x0_in    = CRD_W'(ax0);
        y0_in    = CRD_W'(ay0);
        x1_in    = CRD_W'(ax1);
        y1_in    = CRD_W'(ay1);
        color_in = COL_W'(acol);
    endtask

    task automatic send_seg(input int ax0, input int ay0, input int ax1,
                            input int ay1, input int acol, output int vcyc);
        @(posedge clk); #1;
        vld = 1'b1;
        drive_seg(ax0, ay0, ax1, ay1, acol);
        vcyc = cyc;
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (raster_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", raster_ready); end
        total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b want 0", fb_we); end
        total++; if (fb_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", fb_addr); end
        total++; if (fb_wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %0d want 0", fb_wdata); end
        total++; if (line_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", line_done); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", ovf_err); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %0b want 1", idle); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_horizontal;
        int  base, dbase, vcyc, n;
        bit  ok;
        base  = wr_addr_q.size();
        dbase = done_cnt;
        send_seg(0, 0, 3, 0, 5, vcyc);
        wait_done(dbase + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL horiz_timeout: got no line_done want 1"); end
        wait_cycles(5);
        n = wr_addr_q.size() - base;
        total++; if (n !== 4) begin bad++; $display("FAIL horiz_count: got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++; if (wr_addr_q[base+i] !== i) begin bad++; $display("FAIL horiz_addr[%0d]: got %0d want %0d", i, wr_addr_q[base+i], i); end
            total++; if (wr_data_q[base+i] !== 5) begin bad++; $display("FAIL horiz_data[%0d]: got %0d want 5", i, wr_data_q[base+i]); end
            total++; if (wr_cyc_q[base+i] !== vcyc + 3 + i) begin bad++; $display("FAIL horiz_cycle[%0d]: got %0d want %0d", i, wr_cyc_q[base+i], vcyc + 3 + i); end
        end
        total++; if (done_cnt - dbase !== 1) begin bad++; $display("FAIL horiz_done: got %0d want 1", done_cnt - dbase); end
    endtask

    task automatic test_steep;
        int exp_a [6] = '{6410, 7050, 7691, 8331, 8972, 9612};
        int base, dbase, vcyc, n;
        bit ok;
        base  = wr_addr_q.size();
        dbase = done_cnt;
        send_seg(10, 10, 12, 15, 2, vcyc);
        wait_done(dbase + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL steep_timeout: got no line_done want 1"); end
        wait_cycles(3);
        n = wr_addr_q.size() - base;
        total++; if (n !== 6) begin bad++; $display("FAIL steep_count: got %0d want 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            total++; if (wr_addr_q[base+i] !== exp_a[i] || wr_data_q[base+i] !== 2) begin bad++; $display("FAIL steep_pix[%0d]: got %0d/%0d want %0d/2", i, wr_addr_q[base+i], wr_data_q[base+i], exp_a[i]); end
        end
    endtask

    task automatic test_reverse_point;
        int base, dbase, vcyc, n;
        bit ok;
        base  = wr_addr_q.size();
        dbase = done_cnt;
        send_seg(3, 0, 0, 0, 6, vcyc);
        wait_done(dbase + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL rev_timeout: got no line_done want 1"); end
        wait_cycles(3);
        n = wr_addr_q.size() - base;
        total++; if (n !== 4) begin bad++; $display("FAIL rev_count: got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++; if (wr_addr_q[base+i] !== 3 - i) begin bad++; $display("FAIL rev_addr[%0d]: got %0d want %0d", i, wr_addr_q[base+i], 3 - i); end
        end
        base  = wr_addr_q.size();
        dbase = done_cnt;
        send_seg(639, 479, 639, 479, 7, vcyc);
        wait_done(dbase + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL point_timeout: got no line_done want 1"); end
        wait_cycles(5);
        n = wr_addr_q.size() - base;
        total++; if (n !== 1) begin bad++; $display("FAIL point_count: got %0d want 1", n); end
        if (n >= 1) begin
            total++; if (wr_addr_q[base] !== 307199) begin bad++; $display("FAIL point_addr: got %0d want 307199", wr_addr_q[base]); end
        end
        total++; if (done_cnt - dbase !== 1) begin bad++; $display("FAIL point_done: got %0d want 1", done_cnt - dbase); end
    endtask

    task automatic test_stall;
        int  base, dbase, vcyc, n;
        bit  found, ok;
        base  = wr_addr_q.size();
        dbase = done_cnt;
        found = 1'b0;
        send_seg(0, 0, 3, 0, 4, vcyc);
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (fb_we && fb_addr == 1) begin
                fb_stall = 1'b1;
                found    = 1'b1;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL stall_seen_addr1: got none want addr 1"); end
        if (found) begin
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk); #1;
                total++; if (fb_we !== 1'b1 || fb_addr !== 1) begin bad++; $display("FAIL stall_hold[%0d]: got we=%0b addr=%0d want we=1 addr=1", k, fb_we, fb_addr); end
            end
            fb_stall = 1'b0;
        end
        wait_done(dbase + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no line_done want 1"); end
        wait_cycles(3);
        n = wr_addr_q.size() - base;
        total++; if (n !== 4) begin bad++; $display("FAIL stall_count: got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++; if (wr_addr_q[base+i] !== i) begin bad++; $display("FAIL stall_addr[%0d]: got %0d want %0d", i, wr_addr_q[base+i], i); end
        end
    endtask

    task automatic test_credits;
        int sx0 [3] = '{0, 5, 2};
        int sy0 [3] = '{1, 2, 3};
        int sx1 [3] = '{1, 5, 0};
        int sy1 [3] = '{1, 2, 3};
        int exp_a [6] = '{640, 641, 1285, 1922, 1921, 1920};
        int exp_d [6] = '{1, 1, 2, 3, 3, 3};
        int  base, dbase, idx, viol, n;
        bit  h0, h1, ovf_seen, ok;
        base = wr_addr_q.size();
        dbase = done_cnt;
        idx = 0; viol = 0; h0 = 0; h1 = 0; ovf_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (h1 && idx < 3) begin
                vld = 1'b1;
                drive_seg(sx0[idx], sy0[idx], sx1[idx], sy1[idx], idx + 1);
                idx++;
            end else begin
                vld = 1'b0;
            end
            if (int'(h0) + int'(h1) + int'(raster_ready) > 2) viol++;
            if (ovf_err) ovf_seen = 1'b1;
            h1 = h0;
            h0 = raster_ready;
        end
        vld = 1'b0;
        wait_done(dbase + 3, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL credit_timeout: got %0d line_done want 3", done_cnt - dbase); end
        total++; if (idx !== 3) begin bad++; $display("FAIL credit_sent: got %0d want 3", idx); end
        total++; if (viol !== 0) begin bad++; $display("FAIL credit_window: got %0d violations want 0", viol); end
        total++; if (ovf_seen !== 1'b0) begin bad++; $display("FAIL credit_ovf: got 1 want 0"); end
        wait_cycles(3);
        n = wr_addr_q.size() - base;
        total++; if (n !== 6) begin bad++; $display("FAIL credit_count: got %0d want 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            total++; if (wr_addr_q[base+i] !== exp_a[i] || wr_data_q[base+i] !== exp_d[i]) begin bad++; $display("FAIL credit_pix[%0d]: got %0d/%0d want %0d/%0d", i, wr_addr_q[base+i], wr_data_q[base+i], exp_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_overflow;
        int  base, dbase, vcyc, n;
        bit  seen, ok;
        base  = wr_addr_q.size();
        dbase = done_cnt;
        seen  = 1'b0;
        send_seg(0, 10, 40, 10, 1, vcyc);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (fb_we) seen = 1'b1;
        end
        vld = 1'b1; drive_seg(100, 100, 100, 100, 2);
        @(posedge clk); #1;
        drive_seg(200, 200, 200, 200, 3);
        @(posedge clk); #1;
        drive_seg(300, 300, 300, 300, 4);
        @(posedge clk); #1;
        vld = 1'b0;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", ovf_err); end
        wait_done(dbase + 3, 120, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_timeout: got %0d line_done want 3", done_cnt - dbase); end
        wait_cycles(10);
        n = wr_addr_q.size() - base;
        total++; if (n !== 43) begin bad++; $display("FAIL ovf_count: got %0d want 43", n); end
        if (n >= 43) begin
            total++; if (wr_addr_q[base+40] !== 6440) begin bad++; $display("FAIL ovf_line_end: got %0d want 6440", wr_addr_q[base+40]); end
            total++; if (wr_addr_q[base+41] !== 64100) begin bad++; $display("FAIL ovf_p1: got %0d want 64100", wr_addr_q[base+41]); end
            total++; if (wr_addr_q[base+42] !== 128200) begin bad++; $display("FAIL ovf_p2: got %0d want 128200", wr_addr_q[base+42]); end
        end
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", ovf_err); end
    endtask

    task automatic test_reset_mid;
        int  base, dbase, vcyc, n;
        bit  seen, ok;
        dbase = done_cnt;
        seen  = 1'b0;
        send_seg(0, 20, 30, 20, 6, vcyc);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (fb_we) seen = 1'b1;
        end
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        total++; if (fb_we !== 1'b0 || fb_addr !== '0 || fb_wdata !== '0) begin bad++; $display("FAIL midreset_port: got we=%0b addr=%0d data=%0d want 0/0/0", fb_we, fb_addr, fb_wdata); end
        total++; if (raster_ready !== 1'b0 || line_done !== 1'b0 || ovf_err !== 1'b0) begin bad++; $display("FAIL midreset_flags: got rdy=%0b done=%0b ovf=%0b want 0/0/0", raster_ready, line_done, ovf_err); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL midreset_idle: got %0b want 1", idle); end
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(3);
        total++; if (done_cnt !== dbase) begin bad++; $display("FAIL midreset_nodone: got %0d want %0d", done_cnt, dbase); end
        base  = wr_addr_q.size();
        dbase = done_cnt;
        send_seg(1, 1, 2, 1, 3, vcyc);
        wait_done(dbase + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL after_reset_timeout: got no line_done want 1"); end
        wait_cycles(3);
        n = wr_addr_q.size() - base;
        total++; if (n !== 2) begin bad++; $display("FAIL after_reset_count: got %0d want 2", n); end
        if (n >= 2) begin
            total++; if (wr_addr_q[base] !== 641 || wr_addr_q[base+1] !== 642) begin bad++; $display("FAIL after_reset_addr: got %0d,%0d want 641,642", wr_addr_q[base], wr_addr_q[base+1]); end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_reverse_point();
        test_stall();
        test_credits();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
